chip_pmux_port_a: RTL and testbench

Port A pin multiplexer sitting directly above the pad ring.
- Output direction: selects per pin between GPIO and two alternate functions, and registers the result onto pmux_pad_dout/oe/ie.
- Input direction: synchronises pad_pmux_din into clk_in and produces one-cycle rise/fall pulses for the GPIO interrupt logic.
- Configured through a small register port on the peripheral bus.

---
 rtl/chip_pmux_port_a.sv | 264 ++++++++++++++++++++++++++
 tb/tb_chip_pmux_port_a.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip_pmux_port_a.sv
// Port A pin multiplexer.
// Output side: per-pin select between GPIO, AF1 and AF2 (or parked), registered onto the pads.
// Input side: pad synchroniser, optional glitch filter and one-cycle rise/fall pulses.
// Optional feature macro: PMUX_GLITCH_FILTER_EN builds the per-pin glitch filter counters;
// without it FILT_EN/FILT_LEN decode but read 0 and ignore writes.
module chip_pmux_port_a #(
  parameter int unsigned CHIP_PORT_A_WIDTH = 16,
  parameter int unsigned SYNC_STAGES       = 2
) (
  input  logic                         clk_in,
  input  logic                         rst,

  input  logic [CHIP_PORT_A_WIDTH-1:0] pad_pmux_din,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_dout,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_oe,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_pad_ie,

  input  logic [CHIP_PORT_A_WIDTH-1:0] gpio_dout,
  input  logic [CHIP_PORT_A_WIDTH-1:0] gpio_oe,
  input  logic [CHIP_PORT_A_WIDTH-1:0] gpio_ie,
  input  logic [CHIP_PORT_A_WIDTH-1:0] af1_dout,
  input  logic [CHIP_PORT_A_WIDTH-1:0] af1_oe,
  input  logic [CHIP_PORT_A_WIDTH-1:0] af1_ie,
  input  logic [CHIP_PORT_A_WIDTH-1:0] af2_dout,
  input  logic [CHIP_PORT_A_WIDTH-1:0] af2_oe,
  input  logic [CHIP_PORT_A_WIDTH-1:0] af2_ie,

  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_din,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_din_rise,
  output logic [CHIP_PORT_A_WIDTH-1:0] pmux_din_fall,

  input  logic                         cfg_valid,
  input  logic                         cfg_we,
  input  logic [3:0]                   cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  output logic [31:0]                  cfg_rdata,
  output logic                         cfg_ready
);

  localparam int unsigned W  = CHIP_PORT_A_WIDTH;
  localparam int unsigned FW = 2 * CHIP_PORT_A_WIDTH;

  // Word-address decode (byte address bits [1:0] are ignored).
  localparam logic [1:0] AddrFuncSel = 2'd0;
  localparam logic [1:0] AddrDin     = 2'd1;
  localparam logic [1:0] AddrFiltEn  = 2'd2;
  localparam logic [1:0] AddrFiltLen = 2'd3;

  // ---------------------------------------------------------------------------
  // Register port
  // ---------------------------------------------------------------------------
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rd_val;
  logic          acc_start;
  logic          wr_commit;
  logic [1:0]    word_addr;
  logic [FW-1:0] func_sel_q;

  assign word_addr = cfg_addr[3:2];
  // First cycle of an access raises ready; the write lands on the edge that ends the ready cycle.
  assign acc_start = cfg_valid & ~ready_q;
  assign wr_commit = cfg_valid & ready_q & cfg_we;

  assign cfg_ready = ready_q;
  assign cfg_rdata = rdata_q;

  // Input synchroniser output and pre-edge-detect pin value.
  logic [W-1:0] sync;
  logic [W-1:0] din_prev_q;

`ifdef PMUX_GLITCH_FILTER_EN
  logic [W-1:0] filt_en_q;
  logic [3:0]   filt_len_q;
  logic [3:0]   filt_cnt_q [W];
  logic [W-1:0] filt_din_q;
`endif

  // Read data mux over the register map; unmapped bits read as zero.
  always_comb begin
    rd_val = '0;
    unique case (word_addr)
      AddrFuncSel: rd_val[FW-1:0] = func_sel_q;
      AddrDin:     rd_val[W-1:0]  = pmux_din;
`ifdef PMUX_GLITCH_FILTER_EN
      AddrFiltEn:  rd_val[W-1:0]  = filt_en_q;
      AddrFiltLen: rd_val[3:0]    = filt_len_q;
`else
      AddrFiltEn:  rd_val = '0;
      AddrFiltLen: rd_val = '0;
`endif
      default:     rd_val = '0;
    endcase
  end

  // Handshake: ready pulses for one cycle per access; rdata is zero outside that cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      ready_q <= acc_start;
      rdata_q <= acc_start ? rd_val : 32'd0;
    end
  end

  // FUNC_SEL register; reset value selects GPIO on every pin.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      func_sel_q <= '0;
    end else if (wr_commit && (word_addr == AddrFuncSel)) begin
      func_sel_q <= cfg_wdata[FW-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Output path: per-pin mux then a flop, so the pads never see a glitch
  // ---------------------------------------------------------------------------
  logic [W-1:0] mux_dout;
  logic [W-1:0] mux_oe;
  logic [W-1:0] mux_ie;

  // Select the source function for each pin; code 11 parks the pin fully off.
  always_comb begin
    mux_dout = '0;
    mux_oe   = '0;
    mux_ie   = '0;
    for (int i = 0; i < W; i++) begin
      unique case (func_sel_q[2*i +: 2])
        2'b00: begin
          mux_dout[i] = gpio_dout[i];
          mux_oe[i]   = gpio_oe[i];
          mux_ie[i]   = gpio_ie[i];
        end
        2'b01: begin
          mux_dout[i] = af1_dout[i];
          mux_oe[i]   = af1_oe[i];
          mux_ie[i]   = af1_ie[i];
        end
        2'b10: begin
          mux_dout[i] = af2_dout[i];
          mux_oe[i]   = af2_oe[i];
          mux_ie[i]   = af2_ie[i];
        end
        default: begin
          mux_dout[i] = 1'b0;
          mux_oe[i]   = 1'b0;
          mux_ie[i]   = 1'b0;
        end
      endcase
    end
  end

  // Pad output registers; held at zero through reset so pads stay disabled.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pmux_pad_dout <= '0;
      pmux_pad_oe   <= '0;
      pmux_pad_ie   <= '0;
    end else begin
      pmux_pad_dout <= mux_dout;
      pmux_pad_oe   <= mux_oe;
      pmux_pad_ie   <= mux_ie;
    end
  end

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  logic [W-1:0] sync_q [SYNC_STAGES];

  // Synchroniser chain for the asynchronous pad inputs; independent of FUNC_SEL and ie.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= pad_pmux_din;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef PMUX_GLITCH_FILTER_EN
  // Filter configuration registers.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      filt_en_q  <= '0;
      filt_len_q <= '0;
    end else if (wr_commit) begin
      if (word_addr == AddrFiltEn) begin
        filt_en_q <= cfg_wdata[W-1:0];
      end
      if (word_addr == AddrFiltLen) begin
        filt_len_q <= cfg_wdata[3:0];
      end
    end
  end

  // Per-pin stability counter: a new level is accepted after FILT_LEN+1 mismatching cycles.
  // With the filter off the accepted value simply tracks sync so re-enabling starts clean.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      filt_din_q <= '0;
      for (int i = 0; i < W; i++) begin
        filt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        if (!filt_en_q[i]) begin
          filt_din_q[i] <= sync[i];
          filt_cnt_q[i] <= '0;
        end else if (sync[i] != filt_din_q[i]) begin
          if (filt_cnt_q[i] == filt_len_q) begin
            filt_din_q[i] <= sync[i];
            filt_cnt_q[i] <= '0;
          end else begin
            filt_cnt_q[i] <= filt_cnt_q[i] + 4'd1;
          end
        end else begin
          filt_cnt_q[i] <= '0;
        end
      end
    end
  end

  // Filtered pins take the accepted level; unfiltered pins see sync directly.
  always_comb begin
    pmux_din = '0;
    for (int i = 0; i < W; i++) begin
      pmux_din[i] = filt_en_q[i] ? filt_din_q[i] : sync[i];
    end
  end
`else
  // No filter built: the pin value is the synchroniser output.
  always_comb begin
    pmux_din = sync;
  end
`endif

  // Previous pin value for edge detection; zero after reset so a high pin yields one rise.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      din_prev_q <= '0;
    end else begin
      din_prev_q <= pmux_din;
    end
  end

  // One-cycle transition pulses, coincident with the pmux_din change.
  always_comb begin
    pmux_din_rise = pmux_din & ~din_prev_q;
    pmux_din_fall = ~pmux_din & din_prev_q;
  end

  // Address LSBs and high write-data bits have no function.
  logic unused_cfg;
  assign unused_cfg = ^{cfg_addr[1:0], cfg_wdata};

endmodule

// File: tb/tb_chip_pmux_port_a.sv
// Directed bench for chip_pmux_port_a with default parameters (16 pins, 2 sync stages).
module tb_chip_pmux_port_a;

  localparam int W = 16;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [W-1:0]  pad_pmux_din;
  logic [W-1:0]  pmux_pad_dout, pmux_pad_oe, pmux_pad_ie;
  logic [W-1:0]  gpio_dout, gpio_oe, gpio_ie;
  logic [W-1:0]  af1_dout, af1_oe, af1_ie;
  logic [W-1:0]  af2_dout, af2_oe, af2_ie;
  logic [W-1:0]  pmux_din, pmux_din_rise, pmux_din_fall;
  logic          cfg_valid, cfg_we;
  logic [3:0]    cfg_addr;
  logic [31:0]   cfg_wdata, cfg_rdata;
  logic          cfg_ready;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk_in = ~clk_in;

  chip_pmux_port_a #(
    .CHIP_PORT_A_WIDTH(W),
    .SYNC_STAGES(2)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .pad_pmux_din(pad_pmux_din),
    .pmux_pad_dout(pmux_pad_dout),
    .pmux_pad_oe(pmux_pad_oe),
    .pmux_pad_ie(pmux_pad_ie),
    .gpio_dout(gpio_dout),
    .gpio_oe(gpio_oe),
    .gpio_ie(gpio_ie),
    .af1_dout(af1_dout),
    .af1_oe(af1_oe),
    .af1_ie(af1_ie),
    .af2_dout(af2_dout),
    .af2_oe(af2_oe),
    .af2_ie(af2_ie),
    .pmux_din(pmux_din),
    .pmux_din_rise(pmux_din_rise),
    .pmux_din_fall(pmux_din_fall),
    .cfg_valid(cfg_valid),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .cfg_ready(cfg_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    cfg_valid = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
    chk("wr_ready", 32'(cfg_ready), 32'd1);
    step();
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    chk("wr_ready_drop", 32'(cfg_ready), 32'd0);
  endtask

  task automatic bus_read(input string tag, input logic [3:0] a, input logic [31:0] exp);
    cfg_valid = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = a;
    step();
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    chk({tag, "_rdata"}, cfg_rdata, exp);
    step();
    cfg_valid = 1'b0;
    chk({tag, "_ready_drop"}, 32'(cfg_ready), 32'd0);
    chk({tag, "_rdata_zero"}, cfg_rdata, 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    pad_pmux_din = '0;
    gpio_dout    = 16'hA5A5;
    gpio_oe      = 16'h0F00;
    gpio_ie      = 16'hFFFF;
    af1_dout     = '0;
    af1_oe       = '0;
    af1_ie       = '0;
    af2_dout     = '0;
    af2_oe       = '0;
    af2_ie       = '0;
    cfg_valid    = 1'b0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;

    // Reset: pads disabled even though GPIO sources are active.
    repeat (3) step();
    chk("rst_dout", 32'(pmux_pad_dout), 32'h0);
    chk("rst_oe", 32'(pmux_pad_oe), 32'h0);
    chk("rst_ie", 32'(pmux_pad_ie), 32'h0);
    chk("rst_din", 32'(pmux_din), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    chk("rst_rdata", cfg_rdata, 32'h0);

    rst = 1'b0;
    step();
    chk("gpio_dout", 32'(pmux_pad_dout), 32'hA5A5);
    chk("gpio_oe", 32'(pmux_pad_oe), 32'h0F00);
    chk("gpio_ie", 32'(pmux_pad_ie), 32'hFFFF);

    // Pin 1 to AF1.
    af1_dout = 16'h0002;
    af1_oe   = 16'h0002;
    af1_ie   = 16'h0000;
    bus_write(4'h0, 32'h0000_0004);
    chk("af1_commit_dout", 32'(pmux_pad_dout), 32'hA5A5);
    chk("af1_commit_oe", 32'(pmux_pad_oe), 32'h0F00);
    step();
    chk("af1_dout", 32'(pmux_pad_dout), 32'hA5A7);
    chk("af1_oe", 32'(pmux_pad_oe), 32'h0F02);
    chk("af1_ie", 32'(pmux_pad_ie), 32'hFFFD);

    // Pin 3 parked.
    gpio_dout = 16'hFFFF;
    gpio_oe   = 16'hFFFF;
    bus_write(4'h0, 32'h0000_00C0);
    step();
    chk("park_dout", 32'(pmux_pad_dout), 32'hFFF7);
    chk("park_oe", 32'(pmux_pad_oe), 32'hFFF7);
    chk("park_ie", 32'(pmux_pad_ie), 32'hFFF7);
    bus_read("rd_fsel", 4'h0, 32'h0000_00C0);

    // Pin 0 to AF2, pin 3 still parked.
    af2_dout = 16'h0000;
    af2_oe   = 16'h0001;
    af2_ie   = 16'h0000;
    bus_write(4'h0, 32'h0000_00C2);
    step();
    chk("af2_dout", 32'(pmux_pad_dout), 32'hFFF6);
    chk("af2_oe", 32'(pmux_pad_oe), 32'hFFF7);
    chk("af2_ie", 32'(pmux_pad_ie), 32'hFFF6);
    gpio_oe = 16'h0000;
    step();
    chk("src_latency_oe", 32'(pmux_pad_oe), 32'h0001);
    bus_read("rd_fsel_lsb", 4'h3, 32'h0000_00C2);

`ifdef PMUX_GLITCH_FILTER_EN
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read("rd_flen", 4'hC, 32'h0000_000F);
`else
    bus_write(4'hC, 32'hFFFF_FFFF);
    bus_read("rd_flen", 4'hC, 32'h0000_0000);
    bus_write(4'h8, 32'hFFFF_FFFF);
    bus_read("rd_fen", 4'h8, 32'h0000_0000);
`endif
    bus_write(4'hC, 32'h0000_0000);

    // Pad 5 rising then falling, filter off.
    pad_pmux_din = 16'h0020;
    step();
    chk("sync1_din", 32'(pmux_din), 32'h0);
    chk("sync1_rise", 32'(pmux_din_rise), 32'h0);
    step();
    chk("sync2_din", 32'(pmux_din), 32'h0020);
    chk("sync2_rise", 32'(pmux_din_rise), 32'h0020);
    chk("sync2_fall", 32'(pmux_din_fall), 32'h0);
    step();
    chk("sync3_din", 32'(pmux_din), 32'h0020);
    chk("sync3_rise", 32'(pmux_din_rise), 32'h0);
    bus_read("rd_din", 4'h4, 32'h0000_0020);
    pad_pmux_din = 16'h0000;
    step();
    chk("fall1_din", 32'(pmux_din), 32'h0020);
    step();
    chk("fall2_din", 32'(pmux_din), 32'h0);
    chk("fall2_fall", 32'(pmux_din_fall), 32'h0020);
    step();
    chk("fall3_fall", 32'(pmux_din_fall), 32'h0);

`ifdef PMUX_GLITCH_FILTER_EN
    // Glitch filter on pin 0 with FILT_LEN = 3.
    bus_write(4'h8, 32'h0000_0001);
    bus_write(4'hC, 32'h0000_0003);
    bus_read("rd_flen3", 4'hC, 32'h0000_0003);
    pad_pmux_din = 16'h0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 3) pad_pmux_din = 16'h0000;
      chk("glitch_din", 32'(pmux_din), 32'h0);
      chk("glitch_rise", 32'(pmux_din_rise), 32'h0);
    end
    pad_pmux_din = 16'h0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("stable_din", 32'(pmux_din), (k >= 6) ? 32'h1 : 32'h0);
      chk("stable_rise", 32'(pmux_din_rise), (k == 6) ? 32'h1 : 32'h0);
    end
    pad_pmux_din = 16'h0000;
    repeat (10) step();
`endif

    // Reset aborts a write in its ready cycle.
    cfg_valid = 1'b1;
    cfg_we    = 1'b1;
    cfg_addr  = 4'h0;
    cfg_wdata = 32'h0000_0005;
    step();
    chk("abort_ready_pre", 32'(cfg_ready), 32'd1);
    rst = 1'b1;
    step();
    chk("abort_ready", 32'(cfg_ready), 32'd0);
    chk("abort_rdata", cfg_rdata, 32'd0);
    chk("abort_dout", 32'(pmux_pad_dout), 32'h0);
    chk("abort_oe", 32'(pmux_pad_oe), 32'h0);
    chk("abort_ie", 32'(pmux_pad_ie), 32'h0);
    chk("abort_din", 32'(pmux_din), 32'h0);
    chk("abort_edges", 32'({pmux_din_rise, pmux_din_fall}), 32'h0);
    rst       = 1'b0;
    cfg_valid = 1'b0;
    cfg_we    = 1'b0;
    step();
    chk("post_rst_dout", 32'(pmux_pad_dout), 32'hFFFF);
    chk("post_rst_oe", 32'(pmux_pad_oe), 32'h0000);
    chk("post_rst_ie", 32'(pmux_pad_ie), 32'hFFFF);
    bus_read("rd_fsel_abort", 4'h0, 32'h0);

    // Back-to-back reads with cfg_valid held.
    cfg_valid = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 4'hC;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("b2b_ready", 32'(cfg_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("b2b_rdata", cfg_rdata, 32'd0);
    end
    cfg_valid = 1'b0;
    step();
    chk("b2b_idle", 32'(cfg_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
